// File: rtl/bfly_sched.sv
// Radix-2 DIT in-place FFT butterfly scheduler: walks every stage's butterflies, issues
// operand/twiddle addresses to a fixed-latency datapath and tracks writebacks in a shift pipe.
module bfly_sched #(
  parameter int unsigned LOG2N = 3,
  parameter int unsigned LAT   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       bf_valid,
  input  logic                       bf_ready,
  output logic [LOG2N-1:0]           rd_addr_a,
  output logic [LOG2N-1:0]           rd_addr_b,
  output logic [LOG2N-2:0]           tw_idx,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic                       wr_en,
  output logic [LOG2N-1:0]           wr_addr_a,
  output logic [LOG2N-1:0]           wr_addr_b
);

  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned JW = LOG2N - 1;
  localparam logic [JW-1:0] JLast     = '1;
  localparam logic [SW-1:0] StageLast = SW'(LOG2N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e           state_q;
  logic [JW-1:0]    j_q;
  logic [SW-1:0]    stage_q;
  logic             valid_q, busy_q, done_q;

  logic [LAT-1:0]   pv_q;
  logic [LOG2N-1:0] pa_q [LAT];
  logic [LOG2N-1:0] pb_q [LAT];

  logic             issue, drain_last;
  logic [LAT-1:0]   early;
  logic [LOG2N-1:0] j_ext, hbit, hmask, addr_a;
  logic [JW-1:0]    j_lo;

  assign issue = valid_q & bf_ready;

  // The stage's last writeback is leaving the pipe when nothing younger is still in flight.
  always_comb begin
    early          = pv_q;
    early[LAT-1]   = 1'b0;
  end
  assign drain_last = pv_q[LAT-1] & ~(|early);

  // Butterfly j of stage s: insert a zero at bit s of j to get operand a; b sets that bit.
  always_comb begin
    j_ext  = {1'b0, j_q};
    hbit   = LOG2N'(1) << stage_q;
    hmask  = hbit - LOG2N'(1);
    addr_a = ((j_ext & ~hmask) << 1) | (j_ext & hmask);
    j_lo   = j_q & hmask[JW-1:0];
    rd_addr_a = valid_q ? addr_a : '0;
    rd_addr_b = valid_q ? (addr_a | hbit) : '0;
    tw_idx    = valid_q ? (j_lo << (JW - 32'(stage_q))) : '0;
  end

  assign bf_valid  = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign wr_en     = pv_q[LAT-1];
  assign wr_addr_a = pa_q[LAT-1];
  assign wr_addr_b = pb_q[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= issue;
      pa_q[0] <= rd_addr_a;
      pb_q[0] <= rd_addr_b;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      j_q     <= '0;
      stage_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            j_q     <= '0;
            stage_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (bf_ready) begin
            if (j_q == JLast) begin
              state_q <= StDrain;
              j_q     <= '0;
              valid_q <= 1'b0;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_last) begin
            if (stage_q == StageLast) begin
              state_q <= StFin;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              stage_q <= stage_q + 1'b1;
              j_q     <= '0;
              valid_q <= 1'b1;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          stage_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
